// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    localparam int REG_IDX_W          = 5;
    localparam int DIV_MAX_CYCLES_DEF = 40;

    typedef enum logic {
        RUN      = 1'b0,
        DIV_WAIT = 1'b1
    } state_t;

    // Stage-control bundle in the order the pipeline consumes it.
    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_write;
        logic id_ex_bubble;
        logic ex_mem_bubble;
        logic div_start;
    } ctrl_t;

    function automatic ctrl_t ctrl_normal();
        ctrl_t c;
        c = '0;
        c.pc_write    = 1'b1;
        c.if_id_write = 1'b1;
        c.id_ex_write = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// ID-side hazard inputs and pipeline-control outputs of hazard_controller.
interface hazard_controller_if #(
    parameter int CNT_W = 32
);
    import hazard_pkg::*;

    logic [REG_IDX_W-1:0] id_rs1;
    logic [REG_IDX_W-1:0] id_rs2;
    logic                 id_uses_rs1;
    logic                 id_uses_rs2;
    logic                 ex_mem_read;
    logic [REG_IDX_W-1:0] ex_rd;
    logic                 ex_is_div;
    logic                 ex_branch_taken;
    logic                 div_done;

    logic                 pc_write;
    logic                 if_id_write;
    logic                 if_id_flush;
    logic                 id_ex_write;
    logic                 id_ex_bubble;
    logic                 ex_mem_bubble;
    logic                 div_start;
    logic                 div_timeout;
    logic [CNT_W-1:0]     load_stall_cnt;
    logic [CNT_W-1:0]     div_stall_cnt;
    logic [CNT_W-1:0]     flush_cnt;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_rd,
               ex_is_div, ex_branch_taken, div_done,
        input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
               ex_mem_bubble, div_start, div_timeout,
               load_stall_cnt, div_stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_rd,
               ex_is_div, ex_branch_taken, div_done,
        output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
               ex_mem_bubble, div_start, div_timeout,
               load_stall_cnt, div_stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_perf_counters.sv
// Three saturating event counters: [0] load-use stalls, [1] divide freeze cycles, [2] flushes.
module hazard_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0]            inc,
    output logic [2:0][CNT_W-1:0] cnt
);

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (inc[gi] && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign cnt[gi] = cnt_q;
        end
    endgenerate

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing: load-use stalls, branch flushes and divider freeze/watchdog.
// Perf counters are built only when HAZARD_PERF_CNT_EN is defined; otherwise they read 0.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int DIV_MAX_CYCLES = DIV_MAX_CYCLES_DEF,
    parameter int CNT_W          = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    hazard_controller_if.slave hz
);

    localparam int DCNT_W = (DIV_MAX_CYCLES > 2) ? $clog2(DIV_MAX_CYCLES) : 1;
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DIV_MAX_CYCLES - 1);

    state_t            state_q, state_d;
    logic [DCNT_W-1:0] cnt_q, cnt_d;
    logic              timeout_q, timeout_d;
    logic              load_use;
    ctrl_t             ctrl;

    assign load_use = hz.ex_mem_read && (hz.ex_rd != '0) &&
                      ((hz.id_uses_rs1 && (hz.ex_rd == hz.id_rs1)) ||
                       (hz.id_uses_rs2 && (hz.ex_rd == hz.id_rs2)));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        ctrl      = ctrl_normal();
        unique case (state_q)
            RUN: begin
                if (hz.ex_is_div) begin
                    ctrl.pc_write      = 1'b0;
                    ctrl.if_id_write   = 1'b0;
                    ctrl.id_ex_write   = 1'b0;
                    ctrl.ex_mem_bubble = 1'b1;
                    ctrl.div_start     = 1'b1;
                    cnt_d              = '0;
                    state_d            = DIV_WAIT;
                end else if (hz.ex_branch_taken) begin
                    ctrl.if_id_flush  = 1'b1;
                    ctrl.id_ex_bubble = 1'b1;
                end else if (load_use) begin
                    ctrl.pc_write     = 1'b0;
                    ctrl.if_id_write  = 1'b0;
                    ctrl.id_ex_bubble = 1'b1;
                end
            end
            DIV_WAIT: begin
                // Done wins over the watchdog when both land in the same cycle.
                if (hz.div_done) begin
                    state_d = RUN;
                end else if (cnt_q == DCNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = RUN;
                end else begin
                    ctrl.pc_write      = 1'b0;
                    ctrl.if_id_write   = 1'b0;
                    ctrl.id_ex_write   = 1'b0;
                    ctrl.ex_mem_bubble = 1'b1;
                    cnt_d              = cnt_q + 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
        // Outputs must show the neutral pattern for the whole time reset is held.
        if (!rst_n) begin
            ctrl = ctrl_normal();
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign hz.pc_write      = ctrl.pc_write;
    assign hz.if_id_write   = ctrl.if_id_write;
    assign hz.if_id_flush   = ctrl.if_id_flush;
    assign hz.id_ex_write   = ctrl.id_ex_write;
    assign hz.id_ex_bubble  = ctrl.id_ex_bubble;
    assign hz.ex_mem_bubble = ctrl.ex_mem_bubble;
    assign hz.div_start     = ctrl.div_start;
    assign hz.div_timeout   = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [2:0]            perf_inc;
    logic [2:0][CNT_W-1:0] perf_cnt;

    // Rule-3 is the only case with PC held but ID/EX loading; a freeze holds ID/EX.
    assign perf_inc[0] = ~ctrl.pc_write & ctrl.id_ex_write;
    assign perf_inc[1] = ~ctrl.id_ex_write;
    assign perf_inc[2] = ctrl.if_id_flush;

    hazard_perf_counters #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (perf_inc),
        .cnt   (perf_cnt)
    );

    assign hz.load_stall_cnt = perf_cnt[0];
    assign hz.div_stall_cnt  = perf_cnt[1];
    assign hz.flush_cnt      = perf_cnt[2];
`else
    assign hz.load_stall_cnt = {CNT_W{1'b0}};
    assign hz.div_stall_cnt  = {CNT_W{1'b0}};
    assign hz.flush_cnt      = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: table of single-cycle vectors plus divide/watchdog/reset sequences.
module tb_hazard_controller;
    import hazard_pkg::*;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_bubble, div_start}
    localparam logic [6:0] NORM = 7'b1101000;
    localparam logic [6:0] LUS  = 7'b0001100;
    localparam logic [6:0] BRF  = 7'b1111100;
    localparam logic [6:0] DST  = 7'b0000011;
    localparam logic [6:0] FRZ  = 7'b0000010;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       mr;
        logic [4:0] rd;
        logic       is_div;
        logic       br;
        logic       done;
        logic [6:0] exp;
        string      name;
    } vec_t;

    typedef struct {
        logic [6:0] exp;
        bit         wd;
        string      name;
    } sb_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_controller_if #(.CNT_W(32)) hif ();
    hazard_controller_if #(.CNT_W(32)) wif ();

    assign wif.id_rs1          = hif.id_rs1;
    assign wif.id_rs2          = hif.id_rs2;
    assign wif.id_uses_rs1     = hif.id_uses_rs1;
    assign wif.id_uses_rs2     = hif.id_uses_rs2;
    assign wif.ex_mem_read     = hif.ex_mem_read;
    assign wif.ex_rd           = hif.ex_rd;
    assign wif.ex_is_div       = hif.ex_is_div;
    assign wif.ex_branch_taken = hif.ex_branch_taken;
    assign wif.div_done        = hif.div_done;

    hazard_controller #(.DIV_MAX_CYCLES(40), .CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hif.slave)
    );

    hazard_controller #(.DIV_MAX_CYCLES(4), .CNT_W(32)) dut_wd (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (wif.slave)
    );

    int   n_vec = 0;
    int   n_err = 0;
    sb_t  sb[$];
    vec_t tbl[10];

    function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2, input logic mr,
                                input logic [4:0] rd, input logic is_div, input logic br,
                                input logic done, input logic [6:0] exp, input string name);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.mr = mr; v.rd = rd;
        v.is_div = is_div; v.br = br; v.done = done; v.exp = exp; v.name = name;
        return v;
    endfunction

    function automatic logic [6:0] outs(input bit wd);
        if (wd)
            return {wif.pc_write, wif.if_id_write, wif.if_id_flush, wif.id_ex_write,
                    wif.id_ex_bubble, wif.ex_mem_bubble, wif.div_start};
        return {hif.pc_write, hif.if_id_write, hif.if_id_flush, hif.id_ex_write,
                hif.id_ex_bubble, hif.ex_mem_bubble, hif.div_start};
    endfunction

    task automatic apply(input vec_t v);
        hif.id_rs1 = v.rs1;  hif.id_rs2 = v.rs2;
        hif.id_uses_rs1 = v.u1; hif.id_uses_rs2 = v.u2;
        hif.ex_mem_read = v.mr; hif.ex_rd = v.rd;
        hif.ex_is_div = v.is_div; hif.ex_branch_taken = v.br; hif.div_done = v.done;
    endtask

    task automatic push(input logic [6:0] exp, input bit wd, input string name);
        sb_t e;
        e.exp = exp; e.wd = wd; e.name = name;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        sb_t        e;
        logic [6:0] got;
        e   = sb.pop_front();
        got = outs(e.wd);
        n_vec++;
        if (got !== e.exp) begin
            n_err++;
            $display("FAIL %s: ctrl got %b expected %b", e.name, got, e.exp);
        end else begin
            $display("ok   %s: ctrl %b", e.name, got);
        end
    endtask

    task automatic chk_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end else begin
            $display("ok   %s: %0d", name, got);
        end
    endtask

    task automatic step(input vec_t v, input bit wd);
        @(posedge clk);
        #1;
        apply(v);
        push(v.exp, wd, v.name);
        @(negedge clk);
        pop_check();
    endtask

    task automatic chk_cnts(input string tag, input int ld, input int dv, input int fl);
        chk_val({tag, " load_stall_cnt"}, hif.load_stall_cnt, PERF ? ld : 0);
        chk_val({tag, " div_stall_cnt"},  hif.div_stall_cnt,  PERF ? dv : 0);
        chk_val({tag, " flush_cnt"},      hif.flush_cnt,      PERF ? fl : 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, "idle"));
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    vec_t idle, dstart, frz, rel;

    initial begin
        idle   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, "idle");

        // Outputs during reset with every hazard input asserted.
        apply(mk(5, 5, 1, 1, 1, 5, 1, 1, 1, NORM, "in_reset"));
        #3;
        push(NORM, 0, "reset_outputs");
        pop_check();
        push(NORM, 1, "reset_outputs_wd");
        pop_check();
        chk_val("reset div_timeout", hif.div_timeout, 0);
        chk_cnts("reset", 0, 0, 0);
        do_reset();

        tbl[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, "no_hazard");
        tbl[1] = mk(5, 0, 1, 0, 1, 5, 0, 0, 0, LUS,  "lu_rs1");
        tbl[2] = mk(3, 7, 1, 1, 1, 7, 0, 0, 0, LUS,  "lu_rs2");
        tbl[3] = mk(0, 0, 1, 1, 1, 0, 0, 0, 0, NORM, "x0_exempt");
        tbl[4] = mk(5, 9, 0, 1, 1, 5, 0, 0, 0, NORM, "rs1_unused");
        tbl[5] = mk(5, 5, 1, 1, 0, 5, 0, 0, 0, NORM, "not_load");
        tbl[6] = mk(1, 2, 1, 1, 0, 3, 0, 1, 0, BRF,  "branch");
        tbl[7] = mk(5, 0, 1, 0, 1, 5, 0, 1, 0, BRF,  "branch_beats_lu");
        tbl[8] = mk(4, 4, 1, 1, 0, 0, 0, 0, 1, NORM, "stray_div_done");
        tbl[9] = idle;
        for (int i = 0; i < 10; i++) step(tbl[i], 0);
        chk_cnts("after_table", 2, 0, 2);

        // Divide with 5 frozen wait cycles, release in the DIV_DONE cycle.
        do_reset();
        dstart = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, DST, "div_start");
        frz    = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ, "div_wait");
        rel    = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, NORM, "div_release");
        step(dstart, 0);
        step(frz, 0);
        step(frz, 0);
        step(mk(5, 5, 1, 1, 1, 5, 1, 1, 0, FRZ, "div_wait_ignores_br_lu"), 0);
        step(frz, 0);
        step(frz, 0);
        step(rel, 0);
        step(idle, 0);
        chk_cnts("div_k5", 0, 6, 0);
        chk_val("div_k5 div_timeout", hif.div_timeout, 0);

        // Back-to-back divides restart straight after the release cycle.
        step(dstart, 0);
        step(rel, 0);
        step(dstart, 0);
        step(rel, 0);
        step(idle, 0);
        chk_cnts("div_b2b", 0, 8, 0);

        // Watchdog on the DIV_MAX_CYCLES=4 instance.
        do_reset();
        step(dstart, 1);
        for (int i = 0; i < 3; i++) begin
            step(frz, 1);
            chk_val("wd timeout_low", wif.div_timeout, 0);
        end
        step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, NORM, "wd_expire_release"), 1);
        chk_val("wd timeout_before_edge", wif.div_timeout, 0);
        step(idle, 1);
        chk_val("wd timeout_set", wif.div_timeout, 1);
        step(mk(5, 0, 1, 0, 1, 5, 0, 0, 0, LUS, "wd_back_in_run"), 1);
        chk_val("wd timeout_sticky", wif.div_timeout, 1);
        chk_val("main timeout_clear", hif.div_timeout, 0);

        // Reset asserted in the second DIV_WAIT cycle.
        do_reset();
        step(dstart, 0);
        step(frz, 0);
        @(posedge clk);
        #1;
        apply(mk(5, 5, 1, 1, 1, 5, 1, 1, 0, FRZ, "x"));
        push(FRZ, 0, "pre_reset_wait2");
        #2;
        pop_check();
        #1;
        rst_n = 1'b0;
        #1;
        push(NORM, 0, "mid_div_reset_outputs");
        pop_check();
        chk_cnts("mid_div_reset", 0, 0, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        apply(idle);
        step(idle, 0);
        chk_cnts("after_reset_release", 0, 0, 0);
        step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, DST, "run_after_reset"), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
